// File: rtl/hcu_pkg.sv
// Shared types for the hazard control unit: forwarding select codes,
// control FSM states and the hard-wired zero register index.
package hcu_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } hcu_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hcu_forward_sel.sv
// Forwarding select for one Execute-stage source operand.
// Memory-stage result wins over Writeback; x0 is never forwarded.
module hcu_forward_sel
  import hcu_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output fwd_e       fwd
);

  // Priority select: M stage, then W stage, else register file
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m == rs_e) && (rs_e != REG_X0)) begin
      fwd = FWD_M;
    end else if (reg_write_w && (rd_w == rs_e) && (rs_e != REG_X0)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control for the 5-stage core: forwarding selects, load-use stall,
// branch flush, and a memory-wait FSM with timeout into an error state.
// Optional performance counters are built when HCU_PERF_CNT_EN is defined.
module hazard_control_unit
  import hcu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [4:0] i_Rs1D,
  input  logic [4:0] i_Rs2D,
  input  logic [4:0] i_Rs1E,
  input  logic [4:0] i_Rs2E,
  input  logic [4:0] i_RdE,
  input  logic [4:0] i_RdM,
  input  logic [4:0] i_RdW,
  input  logic       i_LoadE,
  input  logic       i_RegWriteM,
  input  logic       i_RegWriteW,
  input  logic       i_PCSrcE,
  input  logic       i_MemReqM,
  input  logic       i_MemReadyM,
  input  logic       i_ErrAck,
  output logic       o_StallF,
  output logic       o_StallD,
  output logic       o_StallE,
  output logic       o_StallM,
  output logic       o_FlushD,
  output logic       o_FlushE,
  output fwd_e       o_ForwardAE,
  output fwd_e       o_ForwardBE,
  output logic       o_MemErr
`ifdef HCU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_StallCnt,
  output logic [CNT_W-1:0] o_FlushCnt
`endif
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hcu_state_e        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lw_stall;
  logic              mem_hold;

  hcu_forward_sel u_fwd_a (
    .rs_e        (i_Rs1E),
    .rd_m        (i_RdM),
    .rd_w        (i_RdW),
    .reg_write_m (i_RegWriteM),
    .reg_write_w (i_RegWriteW),
    .fwd         (o_ForwardAE)
  );

  hcu_forward_sel u_fwd_b (
    .rs_e        (i_Rs2E),
    .rd_m        (i_RdM),
    .rd_w        (i_RdW),
    .reg_write_m (i_RegWriteM),
    .reg_write_w (i_RegWriteW),
    .fwd         (o_ForwardBE)
  );

  // Memory-wait FSM: wait counter and registered error flag
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      o_MemErr <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (i_MemReqM && !i_MemReadyM) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (i_MemReadyM) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= ERR;
            wait_cnt <= '0;
            o_MemErr <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ERR: begin
          if (i_ErrAck) begin
            state    <= RUN;
            wait_cnt <= '0;
            o_MemErr <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
          o_MemErr <= 1'b0;
        end
      endcase
    end
  end

  // Hazard detection and stall/flush generation; memory hold overrides all
  always_comb begin
    lw_stall = i_LoadE && (i_RdE != REG_X0) && ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));
    mem_hold = ((state == RUN) && i_MemReqM && !i_MemReadyM) || (state != RUN);
    o_StallF = lw_stall || mem_hold;
    o_StallD = lw_stall || mem_hold;
    o_StallE = mem_hold;
    o_StallM = mem_hold;
    o_FlushE = !mem_hold && (lw_stall || i_PCSrcE);
    o_FlushD = !mem_hold && i_PCSrcE;
  end

`ifdef HCU_PERF_CNT_EN
  // Saturating counters of stall-F cycles and flush-E cycles
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      o_StallCnt <= '0;
      o_FlushCnt <= '0;
    end else begin
      if (o_StallF && !(&o_StallCnt)) o_StallCnt <= o_StallCnt + CNT_W'(1);
      if (o_FlushE && !(&o_FlushCnt)) o_FlushCnt <= o_FlushCnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
